fifo_consumer: RTL and testbench

//  Drains a sync FIFO into a single-port SRAM buffer in arbitrated bursts of up to BURST_SIZE words.

---
 rtl/fifo_consumer_if.sv | 21 ++
 rtl/fifo_consumer.sv | 147 ++++++++++++++
 tb/tb_fifo_consumer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_consumer_if.sv
// Consumer-side port of a synchronous FIFO: empty flag, pop strobe and registered read data.
// The draining block takes the master modport; the FIFO takes the slave modport.
interface fifo_consumer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  empty;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        input  empty,
        input  data_out,
        output r_en
    );

    modport slave (
        output empty,
        output data_out,
        input  r_en
    );
endinterface

// File: rtl/fifo_consumer.sv
// Drains a sync FIFO into a single-port SRAM in arbitrated bursts, walking the address
// down by addr_nstep from addr_begin to addr_end, then pulsing done.
module fifo_consumer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 20,
    parameter int BURST_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enb,
    output logic                  done,
    output logic                  request,
    input  logic                  grant,
    input  logic [ADDR_WIDTH-1:0] addr_begin,
    input  logic [ADDR_WIDTH-1:0] addr_nstep,
    input  logic [ADDR_WIDTH-1:0] addr_end,
    fifo_consumer_if.master       consumer,
    output logic                  to_buffer_cs,
    output logic                  to_buffer_oe,
    output logic [ADDR_WIDTH-1:0] to_buffer_addr,
    input  logic [DATA_WIDTH-1:0] to_buffer_R_data,
    output logic                  to_buffer_W_req,
    output logic [DATA_WIDTH-1:0] to_buffer_W_data
);

    localparam logic                  CS_ENB     = 1'b1;
    localparam logic                  CS_DIS     = 1'b0;
    localparam logic                  OE_DIS     = 1'b0;
    localparam logic                  WREQ_ENB   = 1'b1;
    localparam logic                  WREQ_DIS   = 1'b0;
    localparam logic [DATA_WIDTH-1:0] EMPTY_DATA = '0;

    localparam int               CNT_W    = $clog2(BURST_SIZE + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        pop_cnt;
    logic [ADDR_WIDTH-1:0]   pop_addr;
    logic                    last;
    logic                    wr_valid;
    logic                    pop;
    logic                    unused_r_data;

    // The buffer is write-only from this side.
    assign unused_r_data = ^to_buffer_R_data;
    assign to_buffer_oe  = OE_DIS;

    // Request and pop follow the FIFO flag in the same cycle so no word is popped from an empty FIFO.
    always_comb begin
        request = 1'b0;
        pop     = 1'b0;
        case (state)
            S_WAIT:  request = ~consumer.empty;
            S_BURST: begin
                request = 1'b1;
                pop     = ~consumer.empty;
            end
            default: begin
                request = 1'b0;
                pop     = 1'b0;
            end
        endcase
    end

    assign consumer.r_en = pop;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= S_IDLE;
            done           <= 1'b0;
            pop_cnt        <= '0;
            pop_addr       <= '0;
            last           <= 1'b0;
            wr_valid       <= 1'b0;
            to_buffer_addr <= '0;
        end else begin
            done     <= 1'b0;
            wr_valid <= pop;
            if (pop) begin
                to_buffer_addr <= pop_addr;
            end
            case (state)
                S_IDLE: begin
                    if (enb) begin
                        pop_addr <= addr_begin;
                        last     <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (grant && !consumer.empty) begin
                        pop_cnt <= '0;
                        state   <= S_BURST;
                    end
                end
                // Leave the burst on the final address or when the burst quota is used up.
                S_BURST: begin
                    if (pop) begin
                        pop_cnt  <= pop_cnt + 1'b1;
                        pop_addr <= pop_addr - addr_nstep;
                        if (pop_addr == addr_end) begin
                            last  <= 1'b1;
                            state <= S_DRAIN;
                        end else if (pop_cnt == LAST_CNT) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (last) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // A word popped last cycle is now on data_out and is written straight through.
    always_comb begin
        to_buffer_cs     = CS_DIS;
        to_buffer_W_req  = WREQ_DIS;
        to_buffer_W_data = EMPTY_DATA;
        if (wr_valid) begin
            to_buffer_cs     = CS_ENB;
            to_buffer_W_req  = WREQ_ENB;
            to_buffer_W_data = consumer.data_out;
        end
    end

endmodule

// File: tb/tb_fifo_consumer.sv
// Bench for fifo_consumer: a queue-like FIFO model feeds the DUT, an SRAM write logger records
// every write, and each run is compared against hand-computed addresses, data and counts.
module tb_fifo_consumer;

    localparam int DW = 16;
    localparam int AW = 20;
    localparam int BS = 4;

    localparam logic CS_ENB   = 1'b1;
    localparam logic CS_DIS   = 1'b0;
    localparam logic OE_DIS   = 1'b0;
    localparam logic WREQ_ENB = 1'b1;
    localparam logic WREQ_DIS = 1'b0;

    typedef struct {
        logic [AW-1:0] a_begin;
        logic [AW-1:0] a_nstep;
        logic [AW-1:0] a_end;
        int            n_push;
        int            exp_words;
        logic [DW-1:0] data_base;
        logic [AW-1:0] exp_last_addr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          enb = 1'b0;
    logic          grant = 1'b0;
    logic [AW-1:0] addr_begin = '0;
    logic [AW-1:0] addr_nstep = '0;
    logic [AW-1:0] addr_end = '0;
    logic          done;
    logic          request;
    logic          to_buffer_cs;
    logic          to_buffer_oe;
    logic [AW-1:0] to_buffer_addr;
    logic [DW-1:0] to_buffer_R_data = '0;
    logic          to_buffer_W_req;
    logic [DW-1:0] to_buffer_W_data;

    fifo_consumer_if #(.DATA_WIDTH(DW)) bus ();

    fifo_consumer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BURST_SIZE(BS)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .enb             (enb),
        .done            (done),
        .request         (request),
        .grant           (grant),
        .addr_begin      (addr_begin),
        .addr_nstep      (addr_nstep),
        .addr_end        (addr_end),
        .consumer        (bus.master),
        .to_buffer_cs    (to_buffer_cs),
        .to_buffer_oe    (to_buffer_oe),
        .to_buffer_addr  (to_buffer_addr),
        .to_buffer_R_data(to_buffer_R_data),
        .to_buffer_W_req (to_buffer_W_req),
        .to_buffer_W_data(to_buffer_W_data)
    );

    always #5 clk = ~clk;

    // FIFO model: the bench pushes at wr_ptr, the pop process advances rd_ptr.
    logic [DW-1:0] fifo_mem [0:255];
    logic [7:0]    wr_ptr = '0;
    logic [7:0]    rd_ptr = '0;

    assign bus.empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.r_en && !bus.empty) begin
            bus.data_out <= fifo_mem[rd_ptr];
            rd_ptr       <= rd_ptr + 8'd1;
        end
    end

    // SRAM write logger plus counters for done pulses and any OE activity.
    logic [AW-1:0] log_addr [0:1023];
    logic [DW-1:0] log_data [0:1023];
    int            log_cnt = 0;
    int            done_cnt = 0;
    int            oe_bad = 0;

    always @(posedge clk) begin
        if (to_buffer_cs == CS_ENB && to_buffer_W_req == WREQ_ENB) begin
            log_addr[log_cnt[9:0]] <= to_buffer_addr;
            log_data[log_cnt[9:0]] <= to_buffer_W_data;
            log_cnt                <= log_cnt + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
        end
        if (to_buffer_oe != OE_DIS) begin
            oe_bad <= oe_bad + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushWord(input logic [DW-1:0] d);
        fifo_mem[wr_ptr] = d;
        wr_ptr           = wr_ptr + 8'd1;
    endtask

    task automatic flushFifo();
        wr_ptr = rd_ptr;
    endtask

    task automatic startRun(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [AW-1:0] e);
        addr_begin = b;
        addr_nstep = s;
        addr_end   = e;
        enb        = 1'b1;
        @(negedge clk);
        enb        = 1'b0;
    endtask

    task automatic waitDone(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        checkOutput({name, "_done_width"}, 32'(done), 32'd0);
    endtask

    task automatic waitWrites(input int target, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (log_cnt >= target) ok = 1'b1;
            else @(negedge clk);
        end
        checkOutput({name, "_write_wait"}, 32'(ok), 32'd1);
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_done"},    32'(done),             32'd0);
        checkOutput({name, "_request"}, 32'(request),          32'd0);
        checkOutput({name, "_r_en"},    32'(bus.r_en),         32'd0);
        checkOutput({name, "_cs"},      32'(to_buffer_cs),     32'(CS_DIS));
        checkOutput({name, "_oe"},      32'(to_buffer_oe),     32'(OE_DIS));
        checkOutput({name, "_w_req"},   32'(to_buffer_W_req),  32'(WREQ_DIS));
        checkOutput({name, "_w_data"},  32'(to_buffer_W_data), 32'd0);
        checkOutput({name, "_addr"},    32'(to_buffer_addr),   32'd0);
    endtask

    // One complete run: preload, start, wait for done, then compare the write log.
    task automatic applyStimulus(input vec_t v, input string name);
        int            log0;
        int            done0;
        logic [AW-1:0] a;
        grant = 1'b1;
        log0  = log_cnt;
        done0 = done_cnt;
        for (int i = 0; i < v.n_push; i++) pushWord(v.data_base + DW'(i));
        startRun(v.a_begin, v.a_nstep, v.a_end);
        waitDone(name);
        checkOutput({name, "_request_idle"}, 32'(request), 32'd0);
        checkOutput({name, "_writes"}, 32'(log_cnt - log0), 32'(v.exp_words));
        a = v.a_begin;
        for (int i = 0; i < v.exp_words; i++) begin
            checkOutput($sformatf("%s_addr%0d", name, i), 32'(log_addr[10'(log0 + i)]), 32'(a));
            checkOutput($sformatf("%s_data%0d", name, i), 32'(log_data[10'(log0 + i)]), 32'(v.data_base + DW'(i)));
            a = a - v.a_nstep;
        end
        checkOutput({name, "_last_addr"}, 32'(log_addr[10'(log0 + v.exp_words - 1)]), 32'(v.exp_last_addr));
        checkOutput({name, "_fifo_left"}, 32'(8'(wr_ptr - rd_ptr)), 32'(v.n_push - v.exp_words));
        checkOutput({name, "_done_pulses"}, 32'(done_cnt - done0), 32'd1);
        flushFifo();
    endtask

    initial begin
        vec_t vecs [5];
        int   log0;
        int   log_rst;
        int   done0;

        vecs[0] = '{20'd10,  20'd1,       20'd3,       9, 8, 16'h00A0, 20'd3};
        vecs[1] = '{20'd5,   20'd1,       20'd5,       2, 1, 16'h0055, 20'd5};
        vecs[2] = '{20'd1,   20'd1,       20'hFFFFE,   4, 4, 16'h0100, 20'hFFFFE};
        vecs[3] = '{20'd100, 20'hFFFFF,   20'd103,     5, 4, 16'h0200, 20'd103};
        vecs[4] = '{20'd20,  20'd3,       20'd2,       8, 7, 16'h0300, 20'd2};

        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        rstn = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 5; k++) applyStimulus(vecs[k], $sformatf("vec%0d", k));

        // FIFO runs dry mid-burst: the block must hold in BURST without touching the SRAM.
        grant = 1'b1;
        log0  = log_cnt;
        pushWord(16'h00B0);
        pushWord(16'h00B1);
        startRun(20'd2, 20'd1, 20'd0);
        waitWrites(log0 + 2, "stall");
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stall_r_en%0d", i),    32'(bus.r_en),       32'd0);
            checkOutput($sformatf("stall_cs%0d", i),      32'(to_buffer_cs),   32'(CS_DIS));
            checkOutput($sformatf("stall_request%0d", i), 32'(request),        32'd1);
            @(negedge clk);
        end
        pushWord(16'h00B2);
        waitDone("stall");
        checkOutput("stall_writes", 32'(log_cnt - log0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("stall_addr%0d", i), 32'(log_addr[10'(log0 + i)]), 32'(2 - i));
            checkOutput($sformatf("stall_data%0d", i), 32'(log_data[10'(log0 + i)]), 32'(16'h00B0 + i));
        end
        flushFifo();

        // Grant withheld: request stays up, nothing pops until the cycle after grant.
        grant = 1'b0;
        log0  = log_cnt;
        pushWord(16'h00C0);
        pushWord(16'h00C1);
        pushWord(16'h00C2);
        startRun(20'd30, 20'd1, 20'd28);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("nogrant_request%0d", i), 32'(request),      32'd1);
            checkOutput($sformatf("nogrant_r_en%0d", i),    32'(bus.r_en),     32'd0);
            checkOutput($sformatf("nogrant_cs%0d", i),      32'(to_buffer_cs), 32'(CS_DIS));
            @(negedge clk);
        end
        grant = 1'b1;
        @(negedge clk);
        checkOutput("grant_first_pop", 32'(bus.r_en), 32'd1);
        checkOutput("grant_no_early_write", 32'(log_cnt - log0), 32'd0);
        waitDone("grant");
        checkOutput("grant_writes", 32'(log_cnt - log0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("grant_addr%0d", i), 32'(log_addr[10'(log0 + i)]), 32'(30 - i));
        end
        flushFifo();

        // Reset in the middle of a burst, then a fresh run must start from addr_begin again.
        log0  = log_cnt;
        done0 = done_cnt;
        for (int i = 0; i < 8; i++) pushWord(16'h00D0 + DW'(i));
        startRun(20'd10, 20'd1, 20'd3);
        waitWrites(log0 + 2, "midrst");
        rstn = 1'b0;
        @(posedge clk);
        #1;
        log_rst = log_cnt;
        @(negedge clk);
        checkResetOutputs("midrst");
        repeat (3) @(negedge clk);
        checkOutput("midrst_no_writes", 32'(log_cnt - log_rst), 32'd0);
        checkOutput("midrst_no_done", 32'(done_cnt - done0), 32'd0);
        rstn = 1'b1;
        flushFifo();
        @(negedge clk);
        applyStimulus('{20'd10, 20'd1, 20'd9, 2, 2, 16'h00E0, 20'd9}, "restart");

        checkOutput("oe_never_active", 32'(oe_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
